mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: WAIT_CYCLES, default 3, number of SRAM access cycles per transaction (legal range 1..15).
REQ-002 Clk  input  1  system clock; all state changes on rising edge.
REQ-003 Reset  input  1  asynchronous, active-low reset; Reset=0 forces reset state immediately, independent of Clk.
REQ-004 cpu_req  input  1  CPU (ISDU-sequenced datapath) access request; held high until cpu_ack.
REQ-005 cpu_we  input  1  CPU access type: 1=write, 0=read.
REQ-006 cpu_addr  input  16  CPU word address.
REQ-007 cpu_wdata  input  16  CPU write data.
REQ-008 cpu_ack  output  1  one-cycle completion pulse to CPU.
REQ-009 ldr_req  input  1  loader/DMA port access request; held high until ldr_ack.
REQ-010 ldr_we  input  1  loader access type: 1=write, 0=read.
REQ-011 ldr_addr  input  16  loader word address.
REQ-012 ldr_wdata  input  16  loader write data.
REQ-013 ldr_ack  output  1  one-cycle completion pulse to loader.
REQ-014 rdata  output  16  read data register, shared by both ports, valid during and after ack of a read.
REQ-015 busy  output  1  high in any non-IDLE state.
REQ-016 Mem_CE, Mem_OE, Mem_WE  output  1 each  SRAM strobes, active-low.
REQ-017 Mem_ADDR  output  16  SRAM address.
REQ-018 Data_to_SRAM  output  16  SRAM write data; Data_from_SRAM  input  16  SRAM read data.

Function
REQ-019 FSM states SHALL be IDLE, ACCESS, ACK; no other reachable states.
REQ-020 IDLE: if neither req high, stay; else grant one port, latch its we/addr/wdata into internal registers, clear cycle counter, go to ACCESS.
REQ-021 Arbitration SHALL be round-robin: single requester always granted; both requesting -> grant the port not granted last; last-grant register reset value = loader, so CPU wins first contention.
REQ-022 ACCESS: Mem_CE=0, Mem_ADDR=latched addr; read -> Mem_OE=0, Mem_WE=1; write -> Mem_WE=0, Mem_OE=1, Data_to_SRAM=latched wdata; counter increments each cycle.
REQ-023 ACCESS SHALL last exactly WAIT_CYCLES cycles; on the last cycle (counter==WAIT_CYCLES-1) a read captures Data_from_SRAM into rdata, then go to ACK.
REQ-024 ACK: assert ack of granted port only, for exactly one cycle; all Mem strobes high; update last-grant; go to IDLE.
REQ-025 Latency: request sampled at edge N -> ack high in cycle between edges N+WAIT_CYCLES+1 and N+WAIT_CYCLES+2; transaction occupies WAIT_CYCLES+2 cycles including IDLE sample cycle.
REQ-026 Outside ACCESS: Mem_CE=Mem_OE=Mem_WE=1, Mem_ADDR=0, Data_to_SRAM=0.
REQ-027 Latched addr/wdata/we SHALL NOT change during ACCESS even if inputs change.
REQ-028 Request dropped mid-transaction: access completes and ack is still issued.
REQ-029 Requester holding req high in the cycle after its ack SHALL be treated as a new request in IDLE (back-to-back allowed, round-robin applied).
REQ-030 Write transactions SHALL leave rdata unchanged.
REQ-031 cpu_ack and ldr_ack SHALL never be high simultaneously; Mem_OE and Mem_WE SHALL never be low simultaneously.

Reset
REQ-032 On Reset=0: state=IDLE, counter=0, rdata=0, latched regs=0, last-grant=loader, both acks=0, busy=0, Mem strobes=1.
REQ-033 Reset asserted mid-ACCESS SHALL abort the access immediately (strobes high asynchronously) with no ack issued.

Verification
REQ-034 CPU read, WAIT_CYCLES=3, addr=0x0010, SRAM returns 0x1234 -> Mem_OE low 3 cycles, cpu_ack pulses once 4 cycles after sample edge, rdata=0x1234.
REQ-035 Loader write addr=0x0200 data=0xBEEF -> Mem_WE low 3 cycles with Mem_ADDR=0x0200, Data_to_SRAM=0xBEEF, ldr_ack one pulse, rdata unchanged.
REQ-036 Both req high from reset, held continuously -> grants alternate CPU, loader, CPU, loader; no simultaneous acks.
REQ-037 cpu_addr changed from 0x0010 to 0x0FFF during ACCESS -> Mem_ADDR stays 0x0010 through access.
REQ-038 Reset pulsed low during second ACCESS cycle -> strobes high immediately, no ack, busy=0, next CPU request completes normally.
REQ-039 WAIT_CYCLES=1 build, single read -> Mem_OE low exactly 1 cycle, ack 2 cycles after sample edge.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle for mem_arbiter: the CPU and loader request ports, the shared
// read-data/busy status, and the SRAM pin group.
interface mem_arbiter_if;
    logic        cpu_req;
    logic        cpu_we;
    logic [15:0] cpu_addr;
    logic [15:0] cpu_wdata;
    logic        cpu_ack;

    logic        ldr_req;
    logic        ldr_we;
    logic [15:0] ldr_addr;
    logic [15:0] ldr_wdata;
    logic        ldr_ack;

    logic [15:0] rdata;
    logic        busy;

    logic        Mem_CE;
    logic        Mem_OE;
    logic        Mem_WE;
    logic [15:0] Mem_ADDR;
    logic [15:0] Data_to_SRAM;
    logic [15:0] Data_from_SRAM;

    // Arbiter side
    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  ldr_req, ldr_we, ldr_addr, ldr_wdata,
        input  Data_from_SRAM,
        output cpu_ack, ldr_ack, rdata, busy,
        output Mem_CE, Mem_OE, Mem_WE, Mem_ADDR, Data_to_SRAM
    );

    // Requester / SRAM side
    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output ldr_req, ldr_we, ldr_addr, ldr_wdata,
        output Data_from_SRAM,
        input  cpu_ack, ldr_ack, rdata, busy,
        input  Mem_CE, Mem_OE, Mem_WE, Mem_ADDR, Data_to_SRAM
    );
endinterface

// File: rtl/mem_arbiter.sv
// Two-port round-robin SRAM arbiter (CPU and loader). One transaction is an
// IDLE grant cycle, WAIT_CYCLES access cycles with the SRAM strobes driven
// from latched request fields, and a single ack cycle.
module mem_arbiter #(
    parameter int unsigned WAIT_CYCLES = 3
) (
    input  logic          Clk,
    input  logic          Reset,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        ACK    = 2'd2
    } state_t;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_LDR = 1'b1
    } port_t;

    localparam logic [3:0] LAST_CYCLE = 4'(WAIT_CYCLES - 1);

    state_t      state;
    state_t      state_nxt;
    port_t       grant;
    port_t       grant_nxt;
    port_t       last_grant;
    logic [3:0]  cnt;
    logic        lat_we;
    logic [15:0] lat_addr;
    logic [15:0] lat_wdata;
    logic [15:0] rdata_q;

    // Round-robin pick: a lone requester wins, contention goes to the port not served last
    always_comb begin
        grant_nxt = PORT_CPU;
        if (bus.cpu_req && bus.ldr_req) begin
            grant_nxt = (last_grant == PORT_CPU) ? PORT_LDR : PORT_CPU;
        end else if (bus.ldr_req) begin
            grant_nxt = PORT_LDR;
        end
    end

    // State register; reset aborts any access in flight
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and all bus outputs, decoded from state so reset releases strobes at once
    always_comb begin
        state_nxt        = state;
        bus.cpu_ack      = 1'b0;
        bus.ldr_ack      = 1'b0;
        bus.Mem_CE       = 1'b1;
        bus.Mem_OE       = 1'b1;
        bus.Mem_WE       = 1'b1;
        bus.Mem_ADDR     = '0;
        bus.Data_to_SRAM = '0;
        bus.busy         = (state != IDLE);
        bus.rdata        = rdata_q;
        case (state)
            IDLE: begin
                if (bus.cpu_req || bus.ldr_req) begin
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                bus.Mem_CE   = 1'b0;
                bus.Mem_ADDR = lat_addr;
                if (lat_we) begin
                    bus.Mem_WE       = 1'b0;
                    bus.Data_to_SRAM = lat_wdata;
                end else begin
                    bus.Mem_OE = 1'b0;
                end
                if (cnt == LAST_CYCLE) begin
                    state_nxt = ACK;
                end
            end
            ACK: begin
                bus.cpu_ack = (grant == PORT_CPU);
                bus.ldr_ack = (grant == PORT_LDR);
                state_nxt   = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Request latch, access counter, read capture and last-grant bookkeeping
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            grant      <= PORT_CPU;
            last_grant <= PORT_LDR;
            cnt        <= '0;
            lat_we     <= 1'b0;
            lat_addr   <= '0;
            lat_wdata  <= '0;
            rdata_q    <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cpu_req || bus.ldr_req) begin
                        grant <= grant_nxt;
                        cnt   <= '0;
                        if (grant_nxt == PORT_CPU) begin
                            lat_we    <= bus.cpu_we;
                            lat_addr  <= bus.cpu_addr;
                            lat_wdata <= bus.cpu_wdata;
                        end else begin
                            lat_we    <= bus.ldr_we;
                            lat_addr  <= bus.ldr_addr;
                            lat_wdata <= bus.ldr_wdata;
                        end
                    end
                end
                ACCESS: begin
                    cnt <= cnt + 4'd1;
                    if (cnt == LAST_CYCLE && !lat_we) begin
                        rdata_q <= bus.Data_from_SRAM;
                    end
                end
                ACK: begin
                    last_grant <= grant;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: a WAIT_CYCLES=3 instance served by a behavioural
// SRAM, and a WAIT_CYCLES=1 instance for the short-access case.
module tb_mem_arbiter;

    localparam int unsigned W = 3;

    logic Clk;
    logic Reset;

    mem_arbiter_if bus3 ();
    mem_arbiter_if bus1 ();

    mem_arbiter #(.WAIT_CYCLES(3)) dut3 (.Clk(Clk), .Reset(Reset), .bus(bus3));
    mem_arbiter #(.WAIT_CYCLES(1)) dut1 (.Clk(Clk), .Reset(Reset), .bus(bus1));

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;

    logic [15:0] dev_mem   [int];
    logic [15:0] model_mem [int];
    logic        model_last;

    typedef struct packed {
        logic        port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t tbl [7];

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    assign bus1.Data_from_SRAM = 16'h0F1E;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] sram_init(input logic [15:0] a);
        if (a == 16'h0010) return 16'h1234;
        if (a == 16'h8000) return 16'hFFFF;
        return a ^ 16'h5A5A;
    endfunction

    function automatic logic [15:0] dev_rd(input logic [15:0] a);
        if (dev_mem.exists(int'(a))) return dev_mem[int'(a)];
        return sram_init(a);
    endfunction

    function automatic logic [15:0] model_rd(input logic [15:0] a);
        if (model_mem.exists(int'(a))) return model_mem[int'(a)];
        return sram_init(a);
    endfunction

    // Behavioural SRAM behind the W=3 instance
    always @(negedge Clk) begin
        if (!bus3.Mem_CE && !bus3.Mem_OE) bus3.Data_from_SRAM = dev_rd(bus3.Mem_ADDR);
        else                              bus3.Data_from_SRAM = 16'hDEAD;
        if (!bus3.Mem_CE && !bus3.Mem_WE) dev_mem[int'(bus3.Mem_ADDR)] = bus3.Data_to_SRAM;
    end

    // Invariants that must hold in every cycle out of reset
    always @(negedge Clk) begin
        if (Reset) begin
            chk("ack_excl3", {31'b0, bus3.cpu_ack & bus3.ldr_ack}, 0);
            chk("strobe_excl3", {31'b0, ~bus3.Mem_OE & ~bus3.Mem_WE}, 0);
            chk("strobe_excl1", {31'b0, ~bus1.Mem_OE & ~bus1.Mem_WE}, 0);
        end
    end

    task automatic drive_port(input logic port, input logic req, input logic we,
                              input logic [15:0] addr, input logic [15:0] wdata);
        if (!port) begin
            bus3.cpu_req = req; bus3.cpu_we = we; bus3.cpu_addr = addr; bus3.cpu_wdata = wdata;
        end else begin
            bus3.ldr_req = req; bus3.ldr_we = we; bus3.ldr_addr = addr; bus3.ldr_wdata = wdata;
        end
    endtask

    // One single-requester transaction with cycle-by-cycle strobe accounting
    task automatic run_vec(input string tag, input vec_t v);
        int unsigned oe_low = 0, we_low = 0, addr_ok = 0, wd_ok = 0;
        int unsigned acks = 0, ack_at = 0, wrong_ack = 0;
        logic own, other;
        @(posedge Clk); #1;
        drive_port(v.port, 1'b1, v.we, v.addr, v.wdata);
        for (int j = 0; j <= int'(W) + 3; j++) begin
            @(negedge Clk);
            if (j == 0) chk({tag, "_busy_idle"}, {31'b0, bus3.busy}, 0);
            if (j == 1) begin
                chk({tag, "_busy_access"}, {31'b0, bus3.busy}, 1);
                drive_port(v.port, 1'b1, ~v.we, 16'h0FFF, ~v.wdata);
            end
            if (!bus3.Mem_OE) oe_low++;
            if (!bus3.Mem_WE) we_low++;
            if (!bus3.Mem_CE) begin
                if (bus3.Mem_ADDR == v.addr) addr_ok++;
                if (bus3.Data_to_SRAM == (v.we ? v.wdata : 16'h0000)) wd_ok++;
            end
            own   = v.port ? bus3.ldr_ack : bus3.cpu_ack;
            other = v.port ? bus3.cpu_ack : bus3.ldr_ack;
            if (own) begin
                acks++;
                ack_at = j;
                chk({tag, "_rdata_at_ack"}, {16'b0, bus3.rdata}, {16'b0, v.exp_rdata});
                drive_port(v.port, 1'b0, 1'b0, 16'h0, 16'h0);
            end
            if (other) wrong_ack++;
        end
        chk({tag, "_oe_low_cycles"}, oe_low, v.we ? 0 : W);
        chk({tag, "_we_low_cycles"}, we_low, v.we ? W : 0);
        chk({tag, "_addr_held"}, addr_ok, W);
        chk({tag, "_wdata_held"}, wd_ok, W);
        chk({tag, "_ack_count"}, acks, 1);
        chk({tag, "_ack_cycle"}, ack_at, W + 1);
        chk({tag, "_other_ack"}, wrong_ack, 0);
        chk({tag, "_rdata_after"}, {16'b0, bus3.rdata}, {16'b0, v.exp_rdata});
        chk({tag, "_busy_end"}, {31'b0, bus3.busy}, 0);
        if (v.we) model_mem[int'(v.addr)] = v.wdata;
        model_last = v.port;
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic        order [4];
        int unsigned nack;
        logic        exp_q [$];
        logic        e, p;
        logic        cw, lw;
        logic [15:0] ca, la, cd, ld;
        logic [15:0] a_now, d_now;
        logic        we_now;
        int unsigned mode;
        int unsigned oe1, ack1_at, ack_seen;

        tbl[0] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234};
        tbl[1] = '{1'b1, 1'b1, 16'h0200, 16'hBEEF, 16'h1234};
        tbl[2] = '{1'b1, 1'b0, 16'h0200, 16'h0000, 16'hBEEF};
        tbl[3] = '{1'b0, 1'b1, 16'hFFFF, 16'h0001, 16'hBEEF};
        tbl[4] = '{1'b0, 1'b0, 16'h00FF, 16'h0000, 16'h5AA5};
        tbl[5] = '{1'b1, 1'b0, 16'h8000, 16'h0000, 16'hFFFF};
        tbl[6] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h0001};

        Reset = 1'b0;
        drive_port(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        drive_port(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        bus1.cpu_req = 1'b0; bus1.cpu_we = 1'b0; bus1.cpu_addr = '0; bus1.cpu_wdata = '0;
        bus1.ldr_req = 1'b0; bus1.ldr_we = 1'b0; bus1.ldr_addr = '0; bus1.ldr_wdata = '0;
        model_last = 1'b1;

        // Reset state
        repeat (2) @(negedge Clk);
        chk("rst_busy", {31'b0, bus3.busy}, 0);
        chk("rst_acks", {30'b0, bus3.cpu_ack, bus3.ldr_ack}, 0);
        chk("rst_strobes", {29'b0, bus3.Mem_CE, bus3.Mem_OE, bus3.Mem_WE}, 32'h7);
        chk("rst_addr", {16'b0, bus3.Mem_ADDR}, 0);
        chk("rst_wdata", {16'b0, bus3.Data_to_SRAM}, 0);
        chk("rst_rdata", {16'b0, bus3.rdata}, 0);
        chk("rst_strobes_w1", {29'b0, bus1.Mem_CE, bus1.Mem_OE, bus1.Mem_WE}, 32'h7);
        #1 Reset = 1'b1;

        // Both ports requesting from reset and held: grants must alternate, CPU first
        @(posedge Clk); #1;
        drive_port(1'b0, 1'b1, 1'b0, 16'h0030, 16'h0);
        drive_port(1'b1, 1'b1, 1'b0, 16'h0031, 16'h0);
        nack = 0;
        for (int c = 0; c < 40 && nack < 4; c++) begin
            @(negedge Clk);
            if (bus3.cpu_ack || bus3.ldr_ack) begin
                order[nack] = bus3.ldr_ack;
                nack++;
                if (nack == 4) begin
                    drive_port(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
                    drive_port(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
                end
            end
        end
        chk("rr_hold_count", nack, 4);
        for (int i = 0; i < 4; i++) begin
            if (i < int'(nack)) chk("rr_hold_order", {31'b0, order[i]}, i % 2);
        end
        model_last = 1'b1;

        // Directed single-port vectors
        for (int i = 0; i < 7; i++) run_vec($sformatf("vec%0d", i), tbl[i]);

        // Reset pulsed during the second access cycle of a CPU read
        @(posedge Clk); #1;
        drive_port(1'b0, 1'b1, 1'b0, 16'h0010, 16'h0);
        repeat (3) @(negedge Clk);
        chk("abort_in_access", {31'b0, bus3.Mem_CE}, 0);
        Reset = 1'b0;
        drive_port(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        chk("abort_strobes", {29'b0, bus3.Mem_CE, bus3.Mem_OE, bus3.Mem_WE}, 32'h7);
        chk("abort_busy", {31'b0, bus3.busy}, 0);
        chk("abort_rdata", {16'b0, bus3.rdata}, 0);
        #2 Reset = 1'b1;
        ack_seen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge Clk);
            if (bus3.cpu_ack || bus3.ldr_ack) ack_seen++;
        end
        chk("abort_no_ack", ack_seen, 0);
        model_last = 1'b1;
        run_vec("post_abort", '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'h1234});

        // Single-cycle access build
        @(posedge Clk); #1;
        bus1.cpu_req = 1'b1; bus1.cpu_we = 1'b0; bus1.cpu_addr = 16'h0033;
        oe1 = 0; ack1_at = 0; ack_seen = 0;
        for (int j = 0; j < 6; j++) begin
            @(negedge Clk);
            if (!bus1.Mem_OE) oe1++;
            if (bus1.cpu_ack) begin
                ack_seen++;
                ack1_at = j;
                bus1.cpu_req = 1'b0;
            end
        end
        chk("w1_oe_low_cycles", oe1, 1);
        chk("w1_ack_count", ack_seen, 1);
        chk("w1_ack_cycle", ack1_at, 2);
        chk("w1_rdata", {16'b0, bus1.rdata}, 32'h0F1E);

        // Randomized rounds against the reference model
        for (int r = 0; r < 40; r++) begin
            mode = $urandom_range(1, 3);
            cw = 1'($urandom_range(0, 1));
            lw = 1'($urandom_range(0, 1));
            ca = 16'(32'h40 + $urandom_range(0, 7));
            la = 16'(32'h40 + $urandom_range(0, 7));
            cd = 16'($urandom);
            ld = 16'($urandom);
            exp_q.delete();
            if (mode == 3) begin
                e = (model_last == 1'b0) ? 1'b1 : 1'b0;
                exp_q.push_back(e);
                exp_q.push_back(~e);
            end else begin
                exp_q.push_back(mode == 2);
            end
            @(posedge Clk); #1;
            if (mode != 2) drive_port(1'b0, 1'b1, cw, ca, cd);
            if (mode != 1) drive_port(1'b1, 1'b1, lw, la, ld);
            for (int c = 0; c < 40 && exp_q.size() > 0; c++) begin
                @(negedge Clk);
                if (bus3.cpu_ack || bus3.ldr_ack) begin
                    p = bus3.ldr_ack;
                    e = exp_q.pop_front();
                    chk("rand_grant", {31'b0, p}, {31'b0, e});
                    we_now = e ? lw : cw;
                    a_now  = e ? la : ca;
                    d_now  = e ? ld : cd;
                    if (!we_now) chk("rand_rdata", {16'b0, bus3.rdata}, {16'b0, model_rd(a_now)});
                    else         model_mem[int'(a_now)] = d_now;
                    model_last = e;
                    drive_port(p, 1'b0, 1'b0, 16'h0, 16'h0);
                end
            end
            chk("rand_all_acked", exp_q.size(), 0);
            drive_port(1'b0, 1'b0, 1'b0, 16'h0, 16'h0);
            drive_port(1'b1, 1'b0, 1'b0, 16'h0, 16'h0);
        end

        repeat (3) @(negedge Clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
